// File: rtl/shift_sequencer.sv
// Shift functional unit: performs a full-width shift by applying at most STEP
// bit positions per cycle through a narrow shifter, with valid/ready request
// and response handshakes.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holding valid keeps its
// payload stable until that edge. On the response side this unit never drops
// resp_valid or changes resp_res before resp_ready is seen, except on kill or
// rst, which discard the operation.

package isa_pkg;
    typedef enum logic {
        LOGICAL    = 1'b0,
        ARITHMETIC = 1'b1
    } sh_op_t;

    typedef enum logic {
        LEFT_SHIFT  = 1'b0,
        RIGHT_SHIFT = 1'b1
    } sh_dir_t;
endpackage

module shift_sequencer #(
    parameter int LEN  = 32,
    parameter int STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kill,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  isa_pkg::sh_op_t         req_op,
    input  isa_pkg::sh_dir_t        req_dir,
    input  logic [LEN-1:0]          req_src,
    input  logic [$clog2(LEN)-1:0]  req_amount,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LEN-1:0]          resp_res,
    output logic                    busy
);
    import isa_pkg::*;

    // rem is as wide as a shift distance; k needs one extra bit so that
    // STEP == LEN can still be represented.
    localparam int AW = $clog2(LEN);
    localparam int KW = AW + 1;
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [LEN-1:0]  acc, acc_n;
    logic [AW-1:0]   rem, rem_n;
    sh_op_t          op_q, op_n;
    sh_dir_t         dir_q, dir_n;

    logic [KW-1:0]   k;
    logic [LEN-1:0]  step_res;

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            op_q  <= LOGICAL;
            dir_q <= LEFT_SHIFT;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            rem   <= rem_n;
            op_q  <= op_n;
            dir_q <= dir_n;
        end
    end

    // Per-cycle shift distance: the remaining distance, capped at STEP.
    always_comb begin
        k = STEP_K;
        if ({1'b0, rem} <= STEP_K) begin
            k = {1'b0, rem};
        end
    end

    // One narrow shifter step; arithmetic right shifts replicate the sign bit,
    // so iterating them equals a single >>> by the full distance.
    always_comb begin
        step_res = acc;
        if (dir_q == LEFT_SHIFT) begin
            step_res = acc << k;
        end else if (op_q == ARITHMETIC) begin
            step_res = LEN'($signed(acc) >>> k);
        end else begin
            step_res = acc >> k;
        end
    end

    // Next-state and datapath update; kill discards any in-flight operation.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        rem_n   = rem;
        op_n    = op_q;
        dir_n   = dir_q;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    acc_n   = req_src;
                    rem_n   = req_amount;
                    op_n    = req_op;
                    dir_n   = req_dir;
                    state_n = (req_amount != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                acc_n = step_res;
                rem_n = rem - k[AW-1:0];
                if ({1'b0, rem} <= STEP_K) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (kill && (state != IDLE)) begin
            state_n = IDLE;
        end
    end

    // Handshake outputs; the result is only exposed in DONE, never mid-shift.
    always_comb begin
        req_ready  = (state == IDLE) && !kill && !rst;
        resp_valid = (state == DONE) && !rst;
        resp_res   = resp_valid ? acc : '0;
        busy       = (state != IDLE) && !rst;
    end

endmodule
